// File: rtl/calc_pkg.sv
// Shared key codes and sequencer state encoding for the BCD calculator
// front end.
package calc_pkg;

   localparam logic [3:0] KEY_ADD = 4'ha;
   localparam logic [3:0] KEY_SUB = 4'hb;
   localparam logic [3:0] KEY_MUL = 4'hc;
   localparam logic [3:0] KEY_DIV = 4'hd;
   localparam logic [3:0] KEY_EQ  = 4'he;
   localparam logic [3:0] KEY_CLR = 4'hf;

   typedef enum logic [2:0] {
      OP1,
      OP2,
      EVAL,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/calc_operand_acc.sv
// One BCD operand: shift-in of keyed digits with leading-zero suppression
// and a saturating digit count.
module calc_operand_acc #(
   parameter int unsigned DIGITS = 3,
   localparam int unsigned OPW = 4 * DIGITS
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           shift,
   input  logic [3:0]     digit,
   output logic [OPW-1:0] value,
   output logic [OPW-1:0] value_next,
   output logic           has_digit
);

   localparam int unsigned CW = $clog2(DIGITS + 1);

   logic [CW-1:0]  count;
   logic [CW-1:0]  count_next;
   logic [OPW-1:0] base_val;
   logic [CW-1:0]  base_cnt;

   // clr and shift together start a fresh operand holding just this digit
   always_comb begin
      base_val   = clr ? '0 : value;
      base_cnt   = clr ? '0 : count;
      value_next = base_val;
      count_next = base_cnt;
      if (shift && !(base_val == '0 && digit == 4'h0) && base_cnt != CW'(DIGITS)) begin
         value_next = {base_val[OPW-5:0], digit};
         count_next = base_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value <= '0;
         count <= '0;
      end else begin
         value <= value_next;
         count <= count_next;
      end
   end

   assign has_digit = (count != '0);

endmodule

// File: rtl/calc_key_entry.sv
// Keypad operand-entry sequencer: builds two BCD operands and an operator,
// then strobes eval_flag for the arithmetic stage.
module calc_key_entry
   import calc_pkg::*;
#(
   parameter int unsigned DIGITS = 3,
   localparam int unsigned OPW = 4 * DIGITS
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           key_valid,
   input  logic [3:0]     key_code,
   output logic [OPW-1:0] num_reg1,
   output logic [OPW-1:0] num_reg2,
   output logic [3:0]     sym,
   output logic           eval_flag,
   output logic [OPW-1:0] disp_bcd,
   output logic           err
);

   state_t         state, state_next;
   logic [3:0]     sym_next;
   logic           err_next;
   logic           eval_next;
   logic [OPW-1:0] disp_next;
   logic [OPW-1:0] n1_next, n2_next;
   logic           clr1, shift1, clr2, shift2;
   logic           has_digit2;
   logic           is_digit, is_op, is_eq, is_clr;

   calc_operand_acc #(.DIGITS(DIGITS)) u_acc1 (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr1),
      .shift      (shift1),
      .digit      (key_code),
      .value      (num_reg1),
      .value_next (n1_next),
      .has_digit  ()
   );

   calc_operand_acc #(.DIGITS(DIGITS)) u_acc2 (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr2),
      .shift      (shift2),
      .digit      (key_code),
      .value      (num_reg2),
      .value_next (n2_next),
      .has_digit  (has_digit2)
   );

   assign is_digit = key_valid && (key_code <= 4'h9);
   assign is_op    = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
   assign is_eq    = key_valid && (key_code == KEY_EQ);
   assign is_clr   = key_valid && (key_code == KEY_CLR) && (state != EVAL);

   always_comb begin
      state_next = state;
      sym_next   = sym;
      err_next   = err;
      eval_next  = 1'b0;
      clr1       = 1'b0;
      shift1     = 1'b0;
      clr2       = 1'b0;
      shift2     = 1'b0;
      if (is_clr) begin
         clr1       = 1'b1;
         clr2       = 1'b1;
         sym_next   = '0;
         err_next   = 1'b0;
         state_next = OP1;
      end else begin
         unique case (state)
            OP1: begin
               if (is_digit) begin
                  shift1 = 1'b1;
               end else if (is_op) begin
                  sym_next   = key_code;
                  clr2       = 1'b1;
                  state_next = OP2;
               end
            end
            OP2: begin
               if (is_digit) begin
                  shift2 = 1'b1;
               end else if (is_op && !has_digit2) begin
                  sym_next = key_code;
               end else if (is_eq) begin
                  if (sym == KEY_DIV && num_reg2 == '0) begin
                     err_next   = 1'b1;
                     state_next = ERR;
                  end else begin
                     eval_next  = 1'b1;
                     state_next = EVAL;
                  end
               end
            end
            EVAL: state_next = DONE;
            DONE: begin
               if (is_digit) begin
                  clr1       = 1'b1;
                  shift1     = 1'b1;
                  clr2       = 1'b1;
                  sym_next   = '0;
                  state_next = OP1;
               end
            end
            ERR: ;
            default: state_next = OP1;
         endcase
      end
   end

   // Display tracks the operand that will be live in the next state
   always_comb begin
      case (state_next)
         OP2:      disp_next = n2_next;
         OP1, ERR: disp_next = n1_next;
         default:  disp_next = disp_bcd;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= OP1;
         sym       <= '0;
         err       <= 1'b0;
         eval_flag <= 1'b0;
         disp_bcd  <= '0;
      end else begin
         state     <= state_next;
         sym       <= sym_next;
         err       <= err_next;
         eval_flag <= eval_next;
         disp_bcd  <= disp_next;
      end
   end

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry: keys driven on the falling edge,
// outputs sampled on the falling edge after each rising edge.
module tb_calc_key_entry;
   import calc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic [11:0] num_reg1, num_reg2, disp_bcd;
   logic [3:0]  sym;
   logic        eval_flag, err;

   int tests = 0;
   int failed = 0;
   int eval_pulses = 0;

   calc_key_entry dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .num_reg1  (num_reg1),
      .num_reg2  (num_reg2),
      .sym       (sym),
      .eval_flag (eval_flag),
      .disp_bcd  (disp_bcd),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (eval_flag) eval_pulses++;

   // Called at a falling edge; returns at the next falling edge with the key consumed.
   task automatic press(input logic [3:0] k);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if ({num_reg1, num_reg2, sym, eval_flag, disp_bcd, err} !== '0) begin
         $display("FAIL reset_outputs: got %h/%h/%h/%b/%h/%b required all 0", num_reg1, num_reg2, sym, eval_flag, disp_bcd, err); failed++; end
      tests++; if (dut.state !== OP1) begin $display("FAIL reset_state: got %0d required OP1", dut.state); failed++; end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      press(4'h1); press(4'h2); press(4'h3);
      tests++; if (disp_bcd !== 12'h123) begin $display("FAIL basic_disp1: got %h required 123", disp_bcd); failed++; end
      press(KEY_ADD);
      tests++; if (disp_bcd !== 12'h000) begin $display("FAIL basic_disp_op: got %h required 000", disp_bcd); failed++; end
      press(4'h4); press(4'h5);
      tests++; if (disp_bcd !== 12'h045) begin $display("FAIL basic_disp2: got %h required 045", disp_bcd); failed++; end
      press(KEY_EQ);
      tests++; if (eval_flag !== 1'b1) begin $display("FAIL basic_eval_hi: got %b required 1", eval_flag); failed++; end
      tests++; if (dut.state !== EVAL) begin $display("FAIL basic_state_eval: got %0d required EVAL", dut.state); failed++; end
      @(negedge clk);
      tests++; if (eval_flag !== 1'b0) begin $display("FAIL basic_eval_lo: got %b required 0", eval_flag); failed++; end
      tests++; if (dut.state !== DONE) begin $display("FAIL basic_state_done: got %0d required DONE", dut.state); failed++; end
      tests++; if ({num_reg1, num_reg2, sym, disp_bcd} !== {12'h123, 12'h045, 4'ha, 12'h045}) begin
         $display("FAIL basic_regs: got %h %h %h %h required 123 045 a 045", num_reg1, num_reg2, sym, disp_bcd); failed++; end
   endtask

   task automatic test_done_digit;
      int p0;
      press(4'h4);
      tests++; if ({num_reg1, num_reg2, sym, disp_bcd} !== {12'h004, 12'h000, 4'h0, 12'h004}) begin
         $display("FAIL done_digit_regs: got %h %h %h %h required 004 000 0 004", num_reg1, num_reg2, sym, disp_bcd); failed++; end
      tests++; if (dut.state !== OP1) begin $display("FAIL done_digit_state: got %0d required OP1", dut.state); failed++; end
      p0 = eval_pulses;
      press(KEY_EQ);
      repeat (2) @(negedge clk);
      tests++; if (eval_pulses !== p0) begin $display("FAIL op1_eq_no_strobe: got %0d pulses required %0d", eval_pulses, p0); failed++; end
      tests++; if (dut.state !== OP1) begin $display("FAIL op1_eq_state: got %0d required OP1", dut.state); failed++; end
   endtask

   task automatic test_full_and_zeros;
      press(KEY_CLR);
      press(4'h9); press(4'h8); press(4'h7); press(4'h6);
      tests++; if (num_reg1 !== 12'h987) begin $display("FAIL full_op1: got %h required 987", num_reg1); failed++; end
      press(KEY_MUL); press(4'h0); press(4'h0);
      tests++; if (num_reg2 !== 12'h000) begin $display("FAIL lead_zero: got %h required 000", num_reg2); failed++; end
      press(4'h5);
      tests++; if (num_reg2 !== 12'h005) begin $display("FAIL op2_005: got %h required 005", num_reg2); failed++; end
      tests++; if (sym !== KEY_MUL) begin $display("FAIL full_sym: got %h required c", sym); failed++; end
      press(KEY_EQ);
      tests++; if (eval_flag !== 1'b1) begin $display("FAIL mul_eval: got %b required 1", eval_flag); failed++; end
      @(negedge clk);
   endtask

   task automatic test_div_zero;
      int p0;
      press(KEY_CLR);
      p0 = eval_pulses;
      press(4'h7); press(KEY_DIV); press(4'h0); press(KEY_EQ);
      @(negedge clk);
      tests++; if (err !== 1'b1) begin $display("FAIL div0_err: got %b required 1", err); failed++; end
      tests++; if (eval_pulses !== p0) begin $display("FAIL div0_no_eval: got %0d pulses required %0d", eval_pulses, p0); failed++; end
      tests++; if (dut.state !== ERR) begin $display("FAIL div0_state: got %0d required ERR", dut.state); failed++; end
      tests++; if (disp_bcd !== 12'h007) begin $display("FAIL div0_disp: got %h required 007", disp_bcd); failed++; end
      press(4'h3);
      tests++; if (num_reg1 !== 12'h007 || dut.state !== ERR) begin
         $display("FAIL err_ignore: got %h state %0d required 007 ERR", num_reg1, dut.state); failed++; end
      press(KEY_CLR);
      tests++; if ({num_reg1, num_reg2, sym, eval_flag, disp_bcd, err} !== '0) begin
         $display("FAIL clear_outputs: got %h/%h/%h/%b/%h/%b required all 0", num_reg1, num_reg2, sym, eval_flag, disp_bcd, err); failed++; end
      tests++; if (dut.state !== OP1) begin $display("FAIL clear_state: got %0d required OP1", dut.state); failed++; end
   endtask

   task automatic test_op_replace;
      press(4'h5); press(KEY_ADD); press(KEY_SUB);
      tests++; if (sym !== KEY_SUB) begin $display("FAIL op_replace: got %h required b", sym); failed++; end
      press(4'h2); press(KEY_MUL);
      tests++; if (sym !== KEY_SUB) begin $display("FAIL op_no_chain: got %h required b", sym); failed++; end
      press(KEY_EQ);
      tests++; if (eval_flag !== 1'b1 || {num_reg1, num_reg2} !== {12'h005, 12'h002}) begin
         $display("FAIL sub_eval: got %b %h %h required 1 005 002", eval_flag, num_reg1, num_reg2); failed++; end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      press(KEY_CLR);
      press(4'h1); press(KEY_ADD); press(4'h2); press(KEY_EQ);
      press(KEY_CLR); // lands while in EVAL and must be ignored
      tests++; if (dut.state !== DONE || {num_reg1, num_reg2, sym} !== {12'h001, 12'h002, 4'ha}) begin
         $display("FAIL eval_ignores_clr: got state %0d %h %h %h required DONE 001 002 a", dut.state, num_reg1, num_reg2, sym); failed++; end
      tests++; if (eval_flag !== 1'b0) begin $display("FAIL eval_one_cycle: got %b required 0", eval_flag); failed++; end
   endtask

   task automatic test_reset_mid;
      int p0;
      press(KEY_CLR);
      press(4'h1); press(KEY_ADD); press(4'h2);
      p0 = eval_pulses;
      key_valid = 1'b1;
      key_code  = KEY_EQ;
      rst = 1'b0;
      #1;
      tests++; if ({num_reg1, num_reg2, sym, eval_flag, disp_bcd, err} !== '0) begin
         $display("FAIL rst_mid_outputs: got %h/%h/%h/%b/%h/%b required all 0", num_reg1, num_reg2, sym, eval_flag, disp_bcd, err); failed++; end
      @(negedge clk);
      key_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (eval_pulses !== p0) begin $display("FAIL rst_mid_no_eval: got %0d pulses required %0d", eval_pulses, p0); failed++; end
      tests++; if (dut.state !== OP1) begin $display("FAIL rst_mid_state: got %0d required OP1", dut.state); failed++; end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_basic;
      test_done_digit;
      test_full_and_zeros;
      test_div_zero;
      test_op_replace;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
